// File: rtl/swi_debounce.sv
// -----------------------------------------------------------------------------
// swi_debounce
//   Per-bit switch debouncer. Each bit is sampled into s, compared against
//   its accepted (debounced) level, and only accepted once the sampled level
//   has disagreed with it for DEBOUNCE_CYCLES consecutive clock edges. Any
//   return to the accepted level before that point restarts the count.
//
//   Optional feature: define SWI_DEBOUNCE_SYNC2_EN to place a metastability
//   flop in front of the sample register, so s becomes the second of two
//   flops. This adds one edge of latency.
//
// Parameters
//   NBITS            width of the switch bus
//   DEBOUNCE_CYCLES  consecutive mismatching edges required (1..255)
//
// Ports
//   clk_2   in   1      clock, rising edge
//   reset   in   1      synchronous active-high reset
//   sw_in   in   NBITS  raw asynchronous switch levels
//   sw_db   out  NBITS  debounced levels (registered)
//   rise    out  NBITS  one-cycle pulse when a sw_db bit goes 0->1
//   fall    out  NBITS  one-cycle pulse when a sw_db bit goes 1->0
//   stable  out  1      every sampled bit equals its debounced bit
// -----------------------------------------------------------------------------
module swi_debounce #(
  parameter int NBITS           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] sw_in,
  output logic [NBITS-1:0] sw_db,
  output logic [NBITS-1:0] rise,
  output logic [NBITS-1:0] fall,
  output logic             stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value at which the next mismatching edge is the accepting one.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NBITS-1:0] r_s;
  logic [NBITS-1:0] r_db;
  logic [NBITS-1:0] r_rise;
  logic [NBITS-1:0] r_fall;
  logic [CW-1:0]    r_cnt      [NBITS];
  logic [CW-1:0]    w_cnt_nxt  [NBITS];
  logic [NBITS-1:0] w_db_nxt;
  logic [NBITS-1:0] w_s_d;

`ifdef SWI_DEBOUNCE_SYNC2_EN
  // First synchronizer flop; r_s acts as the second.
  logic [NBITS-1:0] r_meta;

  always_ff @(posedge clk_2) begin
    if (reset) r_meta <= '0;
    else       r_meta <= sw_in;
  end

  assign w_s_d = r_meta;
`else
  assign w_s_d = sw_in;
`endif

  // Next debounced level and counter per bit. A counter only advances while
  // the sample disagrees; it clears on agreement or on acceptance, so it
  // never exceeds CNT_LAST.
  always_comb begin
    w_db_nxt = r_db;
    for (int i = 0; i < NBITS; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s[i] != r_db[i]) begin
        if (r_cnt[i] == CNT_LAST) w_db_nxt[i] = r_s[i];
        else                      w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_s    <= '0;
      r_db   <= '0;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < NBITS; i++) r_cnt[i] <= '0;
    end else begin
      r_s    <= w_s_d;
      r_db   <= w_db_nxt;
      // Pulses are registered alongside the level change they describe.
      r_rise <= w_db_nxt & ~r_db;
      r_fall <= ~w_db_nxt & r_db;
      for (int i = 0; i < NBITS; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign sw_db  = r_db;
  assign rise   = r_rise;
  assign fall   = r_fall;
  assign stable = (r_s == r_db);

endmodule

// File: tb/tb_swi_debounce.sv
module tb_swi_debounce;

  localparam int NB = 8;
  localparam int DC = 4;
`ifdef SWI_DEBOUNCE_SYNC2_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam int LAT = DC + D;

  logic          clk_2;
  logic          reset;
  logic [NB-1:0] sw_in;
  logic [NB-1:0] sw_db;
  logic [NB-1:0] rise;
  logic [NB-1:0] fall;
  logic          stable;

  swi_debounce #(.NBITS(NB), .DEBOUNCE_CYCLES(DC)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .sw_in (sw_in),
    .sw_db (sw_db),
    .rise  (rise),
    .fall  (fall),
    .stable(stable)
  );

  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the sampled value travels through a D-deep delay line;
  // per bit, m_run counts consecutive edges at which the sampled level has
  // differed from the accepted level. Reaching DC accepts the new level.
  logic [NB-1:0] m_pipe [D];
  int            m_run  [NB];
  logic [NB-1:0] m_db, m_rise, m_fall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rv, input logic [NB-1:0] iv);
    logic [NB-1:0] s_old;
    s_old = m_pipe[D-1];
    if (rv) begin
      for (int k = 0; k < D; k++) m_pipe[k] = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      m_db = '0; m_rise = '0; m_fall = '0;
    end else begin
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < NB; i++) begin
        if (s_old[i] != m_db[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DC) begin
            m_run[i] = 0;
            m_db[i]  = s_old[i];
            if (s_old[i]) m_rise[i] = 1'b1;
            else          m_fall[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      for (int k = D - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = iv;
    end
  endtask

  task automatic tick(input logic rv, input logic [NB-1:0] iv);
    reset = rv;
    sw_in = iv;
    @(posedge clk_2);
    model_edge(rv, iv);
    #1;
    check("sw_db",  32'(sw_db),  32'(m_db));
    check("rise",   32'(rise),   32'(m_rise));
    check("fall",   32'(fall),   32'(m_fall));
    check("stable", 32'(stable), 32'(m_pipe[D-1] == m_db));
  endtask

  // Hold iv until sw_db changes; report the edge count (0 if it never did).
  task automatic wait_change(input logic [NB-1:0] iv, input int exp_lat, input string tag);
    logic [NB-1:0] prev;
    int n;
    prev = sw_db;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, iv);
      if (sw_db !== prev) begin
        n = k;
        break;
      end
    end
    check(tag, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    int t0, t1;
    logic [NB-1:0] rv_in;

    for (int k = 0; k < D; k++) m_pipe[k] = '0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    m_db = '0; m_rise = '0; m_fall = '0;
    reset = 1'b1;
    sw_in = '0;

    // Reset state and idle with all-zero input.
    tick(1'b1, 8'h00);
    tick(1'b1, 8'h00);
    check("rst_sw_db",  32'(sw_db),  32'h0);
    check("rst_stable", 32'(stable), 32'h1);
    for (int k = 0; k < 10; k++) tick(1'b0, 8'h00);
    check("idle_sw_db", 32'(sw_db), 32'h0);

    // Single bit rising, held.
    wait_change(8'h01, LAT, "lat_rise_b0");
    check("rise_b0_pulse", 32'(rise), 32'h01);
    tick(1'b0, 8'h01);
    check("rise_b0_clear", 32'(rise), 32'h00);
    check("rise_b0_stable", 32'(stable), 32'h1);

    // Glitch on bit 1: high for three edges, then low.
    for (int k = 0; k < 3; k++) tick(1'b0, 8'h03);
    for (int k = 0; k < 8; k++) tick(1'b0, 8'h01);
    check("glitch_sw_db",  32'(sw_db),  32'h01);
    check("glitch_stable", 32'(stable), 32'h1);

    // All high, then upper nibble falls.
    wait_change(8'hFF, LAT, "lat_all_high");
    for (int k = 0; k < 3; k++) tick(1'b0, 8'hFF);
    wait_change(8'h0F, LAT, "lat_fall_hi");
    check("fall_hi_sw_db", 32'(sw_db), 32'h0F);
    check("fall_hi_pulse", 32'(fall),  32'hF0);
    check("fall_hi_rise",  32'(rise),  32'h00);
    tick(1'b0, 8'h0F);
    check("fall_hi_clear", 32'(fall), 32'h00);

    // Reset in the middle of a pending change, then a full restart.
    tick(1'b1, 8'h00);
    for (int k = 0; k < 4; k++) tick(1'b0, 8'h00);
    tick(1'b0, 8'h80);
    tick(1'b0, 8'h80);
    tick(1'b1, 8'h80);
    check("midrst_rise", 32'(rise), 32'h00);
    wait_change(8'h80, LAT, "lat_after_rst");
    check("after_rst_rise", 32'(rise), 32'h80);

    // Bit 1 changes one edge after bit 0.
    tick(1'b1, 8'h00);
    for (int k = 0; k < 4; k++) tick(1'b0, 8'h00);
    t0 = 0; t1 = 0;
    tick(1'b0, 8'h01);
    for (int k = 2; k <= 20; k++) begin
      tick(1'b0, 8'h03);
      if (sw_db[0] && t0 == 0) t0 = k;
      if (sw_db[1] && t1 == 0) t1 = k;
    end
    check("stagger_b0", 32'(t0), 32'(LAT));
    check("stagger_b1", 32'(t1), 32'(LAT + 1));

    // Randomized bouncing with occasional reset.
    rv_in = 8'h00;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) rv_in[$urandom_range(0, NB - 1)] ^= 1'b1;
      tick(($urandom_range(0, 79) == 0), rv_in);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
